// File: rtl/avalon_st_sink_frame_receiver.sv
// Avalon-ST sink: buffers RGB565 frames in a small FIFO and tags each pixel with x/y.
// Optional frame-length checking is compiled in with `define AVST_SINK_FRAME_CHECK_EN.
module avalon_st_sink_frame_receiver #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_W    = 320,
  parameter int FRAME_H    = 240
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready_out,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              startofpacket_in,
  input  logic              endofpacket_in,
  output logic              valid_reg,
  input  logic              ready_reg,
  output logic [DATA_W-1:0] data_reg,
  output logic [9:0]        x_reg,
  output logic [9:0]        y_reg,
  output logic              startofpacket_reg,
  output logic              endofpacket_reg,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err_sop,
  output logic              err_len
);

  localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [9:0]       X_LAST  = 10'(FRAME_W - 1);
  localparam logic [9:0]       Y_LAST  = 10'(FRAME_H - 1);

  typedef enum logic [0:0] {
    ST_WAIT_SOP = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ready_out;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic              r_valid_reg;
  logic [DATA_W-1:0] r_data_reg;
  logic [9:0]        r_x_reg;
  logic [9:0]        r_y_reg;
  logic              r_sop_reg;
  logic              r_eop_reg;
  logic              r_frame_done;
  logic [15:0]       r_frame_count;
  logic              r_err_sop;

  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [9:0]        r_mem_x    [FIFO_DEPTH];
  logic [9:0]        r_mem_y    [FIFO_DEPTH];
  logic              r_mem_sop  [FIFO_DEPTH];
  logic              r_mem_eop  [FIFO_DEPTH];

  logic              w_push;
  logic              w_write;
  logic              w_pop;
  logic              w_mid_sop;
  logic [9:0]        w_wr_x;
  logic [9:0]        w_wr_y;
  logic [9:0]        w_x_adv;
  logic [9:0]        w_y_adv;
  logic [PTR_W-1:0]  w_wr_ptr_next;
  logic [PTR_W-1:0]  w_rd_ptr_next;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_head_valid;
  logic [DATA_W-1:0] w_head_data;
  logic [9:0]        w_head_x;
  logic [9:0]        w_head_y;
  logic              w_head_sop;
  logic              w_head_eop;

  // Only framed beats are written; stray beats before an SOP are accepted and dropped.
  assign w_push    = valid_in && r_ready_out;
  assign w_write   = w_push && ((r_state == ST_IN_FRAME) || startofpacket_in);
  assign w_pop     = r_valid_reg && ready_reg;
  assign w_mid_sop = w_push && (r_state == ST_IN_FRAME) && startofpacket_in;
  assign w_wr_x    = startofpacket_in ? 10'd0 : r_x;
  assign w_wr_y    = startofpacket_in ? 10'd0 : r_y;

  // Write-side framing FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_SOP: begin
        if (w_push && startofpacket_in && !endofpacket_in) w_state_next = ST_IN_FRAME;
        else                                               w_state_next = ST_WAIT_SOP;
      end
      ST_IN_FRAME: begin
        if (w_push && endofpacket_in) w_state_next = ST_WAIT_SOP;
        else                          w_state_next = ST_IN_FRAME;
      end
      default: w_state_next = ST_WAIT_SOP;
    endcase
  end

  // Coordinate advance from the coordinate given to the beat being written
  always_comb begin
    w_x_adv = w_wr_x + 10'd1;
    w_y_adv = w_wr_y;
    if (w_wr_x >= X_LAST) begin
      w_x_adv = 10'd0;
      if (w_wr_y >= Y_LAST) w_y_adv = Y_LAST;
      else                  w_y_adv = w_wr_y + 10'd1;
    end else begin
      w_x_adv = w_wr_x + 10'd1;
      w_y_adv = w_wr_y;
    end
  end

  // FIFO pointer/occupancy next state
  always_comb begin
    w_wr_ptr_next = w_write ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
    w_rd_ptr_next = w_pop   ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    case ({w_write, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Head after this edge; bypass when the head slot is the one being written now
  always_comb begin
    w_head_valid = 1'b0;
    w_head_data  = {DATA_W{1'b0}};
    w_head_x     = 10'd0;
    w_head_y     = 10'd0;
    w_head_sop   = 1'b0;
    w_head_eop   = 1'b0;
    if (w_count_next != {CNT_W{1'b0}}) begin
      w_head_valid = 1'b1;
      if (w_write && (w_rd_ptr_next == r_wr_ptr)) begin
        w_head_data = data_in;
        w_head_x    = w_wr_x;
        w_head_y    = w_wr_y;
        w_head_sop  = startofpacket_in;
        w_head_eop  = endofpacket_in;
      end else begin
        w_head_data = r_mem_data[w_rd_ptr_next];
        w_head_x    = r_mem_x[w_rd_ptr_next];
        w_head_y    = r_mem_y[w_rd_ptr_next];
        w_head_sop  = r_mem_sop[w_rd_ptr_next];
        w_head_eop  = r_mem_eop[w_rd_ptr_next];
      end
    end else begin
      w_head_valid = 1'b0;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_data[r_wr_ptr] <= data_in;
      r_mem_x[r_wr_ptr]    <= w_wr_x;
      r_mem_y[r_wr_ptr]    <= w_wr_y;
      r_mem_sop[r_wr_ptr]  <= startofpacket_in;
      r_mem_eop[r_wr_ptr]  <= endofpacket_in;
    end
  end

  // Control state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_WAIT_SOP;
      r_wr_ptr      <= {PTR_W{1'b0}};
      r_rd_ptr      <= {PTR_W{1'b0}};
      r_count       <= {CNT_W{1'b0}};
      r_ready_out   <= 1'b0;
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_valid_reg   <= 1'b0;
      r_data_reg    <= {DATA_W{1'b0}};
      r_x_reg       <= 10'd0;
      r_y_reg       <= 10'd0;
      r_sop_reg     <= 1'b0;
      r_eop_reg     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'd0;
      r_err_sop     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wr_ptr    <= w_wr_ptr_next;
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_ready_out <= (w_count_next < DEPTH_C);
      if (w_write) begin
        r_x <= w_x_adv;
        r_y <= w_y_adv;
      end
      r_valid_reg  <= w_head_valid;
      r_data_reg   <= w_head_data;
      r_x_reg      <= w_head_x;
      r_y_reg      <= w_head_y;
      r_sop_reg    <= w_head_sop;
      r_eop_reg    <= w_head_eop;
      r_frame_done <= w_pop && r_eop_reg;
      if (w_pop && r_eop_reg) r_frame_count <= r_frame_count + 16'd1;
      r_err_sop    <= w_mid_sop;
    end
  end

`ifdef AVST_SINK_FRAME_CHECK_EN
  localparam logic [16:0] FRAME_BEATS = 17'(FRAME_W * FRAME_H);

  logic [16:0] r_beat_cnt;
  logic [16:0] w_beat_cnt_wr;
  logic        r_err_len;

  assign w_beat_cnt_wr = startofpacket_in ? 17'd1 : (r_beat_cnt + 17'd1);

  // Per-frame beat count; truncated or wrong-length frames latch err_len
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt <= 17'd0;
      r_err_len  <= 1'b0;
    end else begin
      if (w_write) r_beat_cnt <= w_beat_cnt_wr;
      if (w_mid_sop || (w_write && endofpacket_in && (w_beat_cnt_wr != FRAME_BEATS)))
        r_err_len <= 1'b1;
    end
  end

  assign err_len = r_err_len;
`else
  assign err_len = 1'b0;
`endif

  assign ready_out         = r_ready_out;
  assign valid_reg         = r_valid_reg;
  assign data_reg          = r_data_reg;
  assign x_reg             = r_x_reg;
  assign y_reg             = r_y_reg;
  assign startofpacket_reg = r_sop_reg;
  assign endofpacket_reg   = r_eop_reg;
  assign frame_done        = r_frame_done;
  assign frame_count       = r_frame_count;
  assign err_sop           = r_err_sop;

endmodule

// File: tb/tb_avalon_st_sink_frame_receiver.sv
// Directed bench for avalon_st_sink_frame_receiver with a 4x2 frame and a 4-entry FIFO.
module tb_avalon_st_sink_frame_receiver;

  localparam int DW = 16;
`ifdef AVST_SINK_FRAME_CHECK_EN
  localparam logic LEN_CHECK = 1'b1;
`else
  localparam logic LEN_CHECK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ready_out;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = 16'h0000;
  logic          startofpacket_in = 1'b0;
  logic          endofpacket_in = 1'b0;
  logic          valid_reg;
  logic          ready_reg = 1'b0;
  logic [DW-1:0] data_reg;
  logic [9:0]    x_reg;
  logic [9:0]    y_reg;
  logic          startofpacket_reg;
  logic          endofpacket_reg;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          err_sop;
  logic          err_len;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] cap_data [256];
  logic [9:0]    cap_x    [256];
  logic [9:0]    cap_y    [256];
  logic          cap_sop  [256];
  logic          cap_eop  [256];
  int            mon_wr = 0;
  int            done_cnt = 0;
  int            err_sop_cnt = 0;

  always #5 clk = ~clk;

  avalon_st_sink_frame_receiver #(
    .DATA_W(16), .FIFO_DEPTH(4), .FRAME_W(4), .FRAME_H(2)
  ) dut (
    .clk(clk), .reset(reset), .ready_out(ready_out), .valid_in(valid_in),
    .data_in(data_in), .startofpacket_in(startofpacket_in), .endofpacket_in(endofpacket_in),
    .valid_reg(valid_reg), .ready_reg(ready_reg), .data_reg(data_reg),
    .x_reg(x_reg), .y_reg(y_reg), .startofpacket_reg(startofpacket_reg),
    .endofpacket_reg(endofpacket_reg), .frame_done(frame_done), .frame_count(frame_count),
    .err_sop(err_sop), .err_len(err_len)
  );

  // Mid-cycle record of every popped beat and of the one-cycle pulses
  always @(negedge clk) begin
    if (valid_reg === 1'b1 && ready_reg === 1'b1 && mon_wr < 256) begin
      cap_data[mon_wr] <= data_reg;
      cap_x[mon_wr]    <= x_reg;
      cap_y[mon_wr]    <= y_reg;
      cap_sop[mon_wr]  <= startofpacket_reg;
      cap_eop[mon_wr]  <= endofpacket_reg;
      mon_wr           <= mon_wr + 1;
    end
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    if (err_sop === 1'b1) err_sop_cnt <= err_sop_cnt + 1;
  end

  task automatic do_reset();
    reset = 1'b1; valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
    data_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Present one beat and hold it until the sink accepts it; returns 1 time unit after the edge
  task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
    int waited = 0;
    valid_in = 1'b1; data_in = d; startofpacket_in = s; endofpacket_in = e;
    @(negedge clk);
    while (ready_out !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (ready_out !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: ready_out=%b after %0d cycles, required 1", ready_out, waited);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
  endtask

  task automatic wait_caps(input int tgt);
    for (int k = 0; k < 200 && mon_wr < tgt; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; ready_reg = 1'b0; valid_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready_out, valid_reg, startofpacket_reg, endofpacket_reg, frame_done, err_sop, err_len} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got rdy=%b vld=%b sop=%b eop=%b done=%b esop=%b elen=%b, required all 0",
               ready_out, valid_reg, startofpacket_reg, endofpacket_reg, frame_done, err_sop, err_len);
    end
    checks++;
    if ({data_reg, x_reg, y_reg, frame_count} !== 52'd0) begin
      errors++;
      $display("FAIL reset_values: got data=%h x=%0d y=%0d count=%0d, required 0", data_reg, x_reg, y_reg, frame_count);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_up: ready_out=%b, required 1", ready_out);
    end
  endtask

  task automatic test_clean_frame();
    int base; int d0; int s0; time t0;
    do_reset(); ready_reg = 1'b1;
    base = mon_wr; d0 = done_cnt; s0 = err_sop_cnt; t0 = $time;
    for (int i = 0; i < 8; i++) send_beat(16'hA000 + 16'(i), i == 0, i == 7);
    checks++;
    if (($time - t0) !== 64'd80) begin
      errors++;
      $display("FAIL clean_throughput: 8 beats took %0t, required 80", $time - t0);
    end
    wait_caps(base + 8);
    checks++;
    if (mon_wr - base !== 8) begin
      errors++;
      $display("FAIL clean_count: popped %0d, required 8", mon_wr - base);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_data[base+i] !== 16'hA000 + 16'(i) || cap_x[base+i] !== 10'(i % 4) ||
          cap_y[base+i] !== 10'(i / 4) || cap_sop[base+i] !== (i == 0) || cap_eop[base+i] !== (i == 7)) begin
        errors++;
        $display("FAIL clean_beat%0d: got data=%h x=%0d y=%0d sop=%b eop=%b, required data=%h x=%0d y=%0d sop=%b eop=%b",
                 i, cap_data[base+i], cap_x[base+i], cap_y[base+i], cap_sop[base+i], cap_eop[base+i],
                 16'hA000 + 16'(i), i % 4, i / 4, i == 0, i == 7);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || frame_count !== 16'd1 || err_len !== 1'b0 || err_sop_cnt - s0 !== 0) begin
      errors++;
      $display("FAIL clean_status: done=%0d count=%0d err_len=%b err_sop=%0d, required 1 1 0 0",
               done_cnt - d0, frame_count, err_len, err_sop_cnt - s0);
    end
  endtask

  task automatic test_missing_sop();
    int base;
    do_reset(); ready_reg = 1'b1;
    base = mon_wr;
    for (int i = 0; i < 3; i++) send_beat(16'h1110 + 16'(i), 1'b0, i == 2);
    for (int i = 0; i < 8; i++) send_beat(16'hB000 + 16'(i), i == 0, i == 7);
    wait_caps(base + 8);
    checks++;
    if (mon_wr - base !== 8) begin
      errors++;
      $display("FAIL nosop_count: popped %0d, required 8", mon_wr - base);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_data[base+i] !== 16'hB000 + 16'(i) || cap_x[base+i] !== 10'(i % 4) ||
          cap_y[base+i] !== 10'(i / 4) || cap_sop[base+i] !== (i == 0)) begin
        errors++;
        $display("FAIL nosop_beat%0d: got data=%h x=%0d y=%0d sop=%b, required data=%h x=%0d y=%0d sop=%b",
                 i, cap_data[base+i], cap_x[base+i], cap_y[base+i], cap_sop[base+i],
                 16'hB000 + 16'(i), i % 4, i / 4, i == 0);
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL nosop_frame_count: got %0d, required 1", frame_count);
    end
  endtask

  task automatic test_backpressure();
    int base;
    do_reset(); ready_reg = 1'b0;
    base = mon_wr;
    for (int i = 0; i < 4; i++) begin
      send_beat(16'hC000 + 16'(i), i == 0, 1'b0);
      if (i == 2) begin
        checks++;
        if (ready_out !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_3: ready_out=%b with 3 queued, required 1", ready_out);
        end
      end
    end
    checks++;
    if (ready_out !== 1'b0 || valid_reg !== 1'b1 || data_reg !== 16'hC000) begin
      errors++;
      $display("FAIL bp_full: rdy=%b vld=%b data=%h, required 0 1 c000", ready_out, valid_reg, data_reg);
    end
    valid_in = 1'b1; data_in = 16'hC004; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready_out !== 1'b0 || data_reg !== 16'hC000 || mon_wr !== base) begin
      errors++;
      $display("FAIL bp_hold: rdy=%b data=%h popped=%0d, required 0 c000 0", ready_out, data_reg, mon_wr - base);
    end
    @(posedge clk); #1 ready_reg = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_before_pop: ready_out=%b, required 0", ready_out);
    end
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after_pop: ready_out=%b, required 1", ready_out);
    end
    @(posedge clk); #1 valid_in = 1'b0;
    wait_caps(base + 5);
    checks++;
    if (mon_wr - base !== 5) begin
      errors++;
      $display("FAIL bp_count: popped %0d, required 5", mon_wr - base);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap_data[base+i] !== 16'hC000 + 16'(i) || cap_x[base+i] !== 10'(i % 4) || cap_y[base+i] !== 10'(i / 4)) begin
        errors++;
        $display("FAIL bp_beat%0d: got data=%h x=%0d y=%0d, required data=%h x=%0d y=%0d",
                 i, cap_data[base+i], cap_x[base+i], cap_y[base+i], 16'hC000 + 16'(i), i % 4, i / 4);
      end
    end
  endtask

  task automatic test_early_sop();
    int base; int s0;
    int ex [8] = '{0, 1, 2, 3, 0, 0, 1, 2};
    int ey [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    do_reset(); ready_reg = 1'b1;
    base = mon_wr; s0 = err_sop_cnt;
    for (int i = 0; i < 8; i++) begin
      send_beat(16'hD000 + 16'(i), (i == 0) || (i == 5), i == 7);
      if (i == 5) begin
        checks++;
        if (err_sop !== 1'b1) begin
          errors++;
          $display("FAIL esop_pulse_timing: err_sop=%b after early SOP push, required 1", err_sop);
        end
      end
    end
    wait_caps(base + 8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_data[base+i] !== 16'hD000 + 16'(i) || cap_x[base+i] !== 10'(ex[i]) || cap_y[base+i] !== 10'(ey[i]) ||
          cap_sop[base+i] !== ((i == 0) || (i == 5)) || cap_eop[base+i] !== (i == 7)) begin
        errors++;
        $display("FAIL esop_beat%0d: got data=%h x=%0d y=%0d sop=%b eop=%b, required data=%h x=%0d y=%0d",
                 i, cap_data[base+i], cap_x[base+i], cap_y[base+i], cap_sop[base+i], cap_eop[base+i],
                 16'hD000 + 16'(i), ex[i], ey[i]);
      end
    end
    checks++;
    if (err_sop_cnt - s0 !== 1 || err_len !== LEN_CHECK || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL esop_status: err_sop pulses=%0d err_len=%b count=%0d, required 1 %b 1",
               err_sop_cnt - s0, err_len, frame_count, LEN_CHECK);
    end
  endtask

  task automatic test_short_frame();
    int base;
    do_reset(); ready_reg = 1'b1;
    base = mon_wr;
    for (int i = 0; i < 7; i++) send_beat(16'hE000 + 16'(i), i == 0, i == 6);
    wait_caps(base + 7);
    checks++;
    if (mon_wr - base !== 7 || cap_x[base+6] !== 10'd2 || cap_y[base+6] !== 10'd1 || cap_eop[base+6] !== 1'b1) begin
      errors++;
      $display("FAIL short_last: popped=%0d x=%0d y=%0d eop=%b, required 7 2 1 1",
               mon_wr - base, cap_x[base+6], cap_y[base+6], cap_eop[base+6]);
    end
    checks++;
    if (err_len !== LEN_CHECK || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL short_status: err_len=%b count=%0d, required %b 1", err_len, frame_count, LEN_CHECK);
    end
  endtask

  task automatic test_saturate_single();
    int base; int d0;
    do_reset(); ready_reg = 1'b1;
    base = mon_wr; d0 = done_cnt;
    for (int i = 0; i < 10; i++) send_beat(16'h4000 + 16'(i), i == 0, i == 9);
    send_beat(16'h5555, 1'b1, 1'b1);
    send_beat(16'h6666, 1'b0, 1'b0);
    wait_caps(base + 11);
    checks++;
    if (mon_wr - base !== 11) begin
      errors++;
      $display("FAIL sat_count: popped %0d, required 11", mon_wr - base);
    end
    checks++;
    if (cap_x[base+8] !== 10'd0 || cap_y[base+8] !== 10'd1 || cap_x[base+9] !== 10'd1 || cap_y[base+9] !== 10'd1) begin
      errors++;
      $display("FAIL sat_y: beat8=(%0d,%0d) beat9=(%0d,%0d), required (0,1) (1,1)",
               cap_x[base+8], cap_y[base+8], cap_x[base+9], cap_y[base+9]);
    end
    checks++;
    if (cap_data[base+10] !== 16'h5555 || cap_sop[base+10] !== 1'b1 || cap_eop[base+10] !== 1'b1 ||
        cap_x[base+10] !== 10'd0 || cap_y[base+10] !== 10'd0) begin
      errors++;
      $display("FAIL single_beat: data=%h sop=%b eop=%b x=%0d y=%0d, required 5555 1 1 0 0",
               cap_data[base+10], cap_sop[base+10], cap_eop[base+10], cap_x[base+10], cap_y[base+10]);
    end
    checks++;
    if (done_cnt - d0 !== 2 || frame_count !== 16'd2) begin
      errors++;
      $display("FAIL single_frames: done=%0d count=%0d, required 2 2", done_cnt - d0, frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    do_reset(); ready_reg = 1'b1;
    base = mon_wr;
    for (int i = 0; i < 8; i++) send_beat(16'hF000 + 16'(i), i == 0, i == 7);
    wait_caps(base + 8);
    @(posedge clk); #1 ready_reg = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(16'h7770 + 16'(i), i == 0, 1'b0);
    checks++;
    if (valid_reg !== 1'b1 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL rmid_pre: valid=%b count=%0d, required 1 1", valid_reg, frame_count);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready_out, valid_reg, startofpacket_reg, endofpacket_reg, frame_done, err_sop, err_len} !== 7'b0 ||
        {data_reg, x_reg, y_reg, frame_count} !== 52'd0) begin
      errors++;
      $display("FAIL rmid_flush: rdy=%b vld=%b data=%h x=%0d y=%0d count=%0d err_len=%b, required all 0",
               ready_out, valid_reg, data_reg, x_reg, y_reg, frame_count, err_len);
    end
    @(posedge clk); #1 reset = 1'b0; ready_reg = 1'b1;
    @(posedge clk); #1;
    base = mon_wr;
    send_beat(16'h7773, 1'b0, 1'b0);
    send_beat(16'h7774, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send_beat(16'h8880 + 16'(i), i == 0, i == 7);
    wait_caps(base + 8);
    checks++;
    if (mon_wr - base !== 8) begin
      errors++;
      $display("FAIL rmid_count: popped %0d, required 8", mon_wr - base);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_data[base+i] !== 16'h8880 + 16'(i) || cap_x[base+i] !== 10'(i % 4) || cap_y[base+i] !== 10'(i / 4)) begin
        errors++;
        $display("FAIL rmid_beat%0d: got data=%h x=%0d y=%0d, required data=%h x=%0d y=%0d",
                 i, cap_data[base+i], cap_x[base+i], cap_y[base+i], 16'h8880 + 16'(i), i % 4, i / 4);
      end
    end
    checks++;
    if (frame_count !== 16'd1 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL rmid_status: count=%0d err_len=%b, required 1 0", frame_count, err_len);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_missing_sop();
    test_backpressure();
    test_early_sop();
    test_short_frame();
    test_saturate_single();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_st_sink_frame_receiver.md
# avalon_st_sink_frame_receiver

Avalon-ST sink endpoint for the video IP's input side. It accepts the RGB565 pixel stream from the upstream DMA pixel source and buffers it in a small FIFO. It enforces frame framing via `startofpacket`/`endofpacket` and presents each buffered pixel to the IP core tagged with its x/y coordinate. It is the receiving counterpart of the IP's streaming source interface, so a complete stream path is sink → IP core → source.

## Interface
Parameters:
- `DATA_W`, 16: pixel width (RGB565).
- `FIFO_DEPTH`, 4: buffer entries; must be a power of 2 and ≥ 2.
- `FRAME_W`, 320: pixels per line.
- `FRAME_H`, 240: lines per frame.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `ready_out`  out  1  to upstream source; sink can accept a beat this cycle.
- `valid_in`  in  1  upstream beat valid.
- `data_in`  in  DATA_W  upstream pixel.
- `startofpacket_in`  in  1  first pixel of frame.
- `endofpacket_in`  in  1  last pixel of frame.
- `valid_reg`  out  1  FIFO head valid, toward IP.
- `ready_reg`  in  1  IP accepts head this cycle.
- `data_reg`  out  DATA_W  head pixel.
- `x_reg`  out  10  head column, 0..FRAME_W-1.
- `y_reg`  out  10  head line, 0..FRAME_H-1.
- `startofpacket_reg` / `endofpacket_reg`  out  1  head framing flags.
- `frame_done`  out  1  one-cycle pulse when an EOP beat is popped.
- `frame_count`  out  16  frames popped; wraps at 0xFFFF→0.
- `err_sop`  out  1  one-cycle pulse on an SOP received mid-frame.
- `err_len`  out  1  sticky frame-length error; see Configuration.

## Operation
- Accept: `push = valid_in && ready_out`. Ready latency 0.
- Write-side FSM:
  - **WAIT_SOP** (reset state):
    - Accepted beats without SOP are discarded and not written.
    - SOP beat is written with x=0,y=0. Then go to IN_FRAME, unless EOP is also set, in which case it is a single-beat frame and the FSM stays in WAIT_SOP.
  - **IN_FRAME**:
    - Each accepted beat is written with the current x/y.
    - EOP beat is written, then go to WAIT_SOP.
    - SOP beat: pulse `err_sop`; write the beat as the start of a new frame with x=0,y=0 and its SOP flag set; stay in IN_FRAME.
- Coordinate counters (write side):
  - x increments per written beat.
  - At x=FRAME_W-1, x wraps to 0 and y increments.
  - y saturates at FRAME_H-1.
  - Both counters reset to 0 on every SOP.
- FIFO entry: {data, x, y, sop, eop}.
- Read side:
  - `valid_reg = !empty`; outputs show the head entry.
  - `pop = valid_reg && ready_reg`.
  - While `valid_reg`=0, `data_reg`, `x_reg`, `y_reg`, `startofpacket_reg` and `endofpacket_reg` are held at 0.
- Pop of an EOP entry: `frame_done` pulses and `frame_count` increments, both on the cycle after the pop.

## Timing
- Reset values: `ready_out`=0, `valid_reg`=0, all data/flag/coordinate outputs 0, `frame_count`=0, `frame_done`=0, `err_sop`=0, `err_len`=0. FIFO is empty and the FSM is in WAIT_SOP.
- `ready_out` is registered: `ready_out <= (occupancy_next < FIFO_DEPTH)`. It is 1 on the first cycle after reset deasserts.
- Latency: a beat pushed on edge N is visible at `valid_reg` after edge N; it can be popped on edge N+1.
- Simultaneous push and pop: occupancy is unchanged. When the FIFO is full, `ready_out` is already 0, so no push occurs; one pop re-asserts `ready_out` on the next edge.
- Sustained throughput: 1 beat/cycle when `ready_reg` is held at 1.
- `err_sop` pulses on the cycle after the offending push.
- Reset mid-frame: the FIFO is flushed, counters are cleared, the FSM returns to WAIT_SOP and `err_len` is cleared. The remainder of the interrupted frame is discarded until the next SOP.

## Configuration
- `AVST_SINK_FRAME_CHECK_EN` defined:
  - A 17-bit beat counter counts written beats per frame.
  - When an EOP beat is written, `err_len` is set if the count ≠ FRAME_W*FRAME_H.
  - An SOP received mid-frame (truncated frame) also sets `err_len`.
  - `err_len` stays set until reset.
- Not defined: the beat counter is absent and `err_len` is tied to 0. All other behaviour is identical.

## Test plan
- Clean frame, FRAME_W=4, FRAME_H=2, `ready_reg`=1: 8 beats, SOP on beat 0, EOP on beat 7.
  - Coordinates out: (0,0)…(3,0), (0,1)…(3,1).
  - One `frame_done`; `frame_count`=1; `err_len`=0.
- Missing SOP: 3 beats without SOP, then a valid frame. The 3 beats never appear at `valid_reg`; the frame passes intact.
- Backpressure, FIFO_DEPTH=4: hold `ready_reg`=0 and push 5 beats.
  - `ready_out` drops after the 4th beat; the 5th beat is held by upstream.
  - Release `ready_reg`: all 5 beats emerge in order with no loss or duplication.
- Early SOP: SOP at beat 5 of an 8-beat frame.
  - `err_sop` pulses; beat 5 emerges with x=0,y=0 and SOP set.
  - With the macro defined, `err_len`=1.
- Short frame with the macro defined: EOP at beat 6 of 8 → `err_len`=1, `frame_count`=1. Without the macro, `err_len` stays 0.
- Reset mid-frame after 3 beats: all outputs return to reset values. A following clean frame yields `frame_count`=1 and coordinates starting at (0,0).
